branch_redirect_unit: RTL

Sits directly downstream of the execute-stage branch unit and turns each resolved control-flow outcome into front-end actions. It compares the resolved next PC against the fetch-time prediction and detects mispredictions. On a misprediction it holds a PC redirect request to fetch under a valid/ready handshake and flushes younger wrong-path instructions. For every resolved branch it issues a registered update to the branch predictor.

---
 rtl/branch_redirect_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: turns resolved branch outcomes into fetch redirects, flushes and predictor updates.
// Optional saturating statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_unit #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic            is_branch_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            taken_i,
    input  logic [PC_W-1:0] result_i,
    input  logic            pred_taken_i,
    input  logic [PC_W-1:0] pred_addr_i,
    output logic            redirect_valid_o,
    output logic [PC_W-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            flush_o,
    output logic            busy_o,
    output logic            bp_update_valid_o,
    output logic [PC_W-1:0] bp_update_pc_o,
    output logic            bp_update_taken_o,
    output logic [PC_W-1:0] bp_update_target_o,
    output logic [CNT_W-1:0] resolved_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t state;
    logic   accept;
    logic   mispredict;

    // busy_o is the registered REDIRECT indicator, so acceptance has no output-to-input loop
    assign accept     = valid_i & is_branch_i & ~busy_o;
    assign mispredict = (taken_i != pred_taken_i) | (result_i != pred_addr_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        state            <= REDIRECT;
                        redirect_pc_o    <= result_i;
                        redirect_valid_o <= 1'b1;
                        flush_o          <= 1'b1;
                        busy_o           <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        state            <= IDLE;
                        redirect_valid_o <= 1'b0;
                        flush_o          <= 1'b0;
                        busy_o           <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    redirect_valid_o <= 1'b0;
                    flush_o          <= 1'b0;
                    busy_o           <= 1'b0;
                end
            endcase
        end
    end

    // Update payload holds its last value between pulses; only the valid bit pulses
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bp_update_valid_o  <= 1'b0;
            bp_update_pc_o     <= '0;
            bp_update_taken_o  <= 1'b0;
            bp_update_target_o <= '0;
        end else begin
            bp_update_valid_o <= accept;
            if (accept) begin
                bp_update_pc_o     <= pc_i;
                bp_update_taken_o  <= taken_i;
                bp_update_target_o <= result_i;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] resolved_q;
    logic [CNT_W-1:0] mispredict_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resolved_q   <= '0;
            mispredict_q <= '0;
        end else begin
            if (accept && !(&resolved_q))
                resolved_q <= resolved_q + 1'b1;
            if (accept && mispredict && !(&mispredict_q))
                mispredict_q <= mispredict_q + 1'b1;
        end
    end

    assign resolved_cnt_o   = resolved_q;
    assign mispredict_cnt_o = mispredict_q;
`else
    assign resolved_cnt_o   = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule
